// File: rtl/sliding_window_3x3.sv
// 3x3 sliding-window generator for a raster-order pixel stream.
// Two line buffers hold the previous two rows; a 3x3 register array holds the
// current window. A window is emitted only when it lies fully inside the frame.
module sliding_window_3x3 #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned IMAGE_WIDTH  = 640,
  parameter int unsigned IMAGE_HEIGHT = 480,
  parameter int unsigned OUTPUT_WIDTH = DATA_WIDTH * 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] kernel
);

  localparam int unsigned COL_W = $clog2(IMAGE_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMAGE_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  // StFill: rows 0 and 1, nothing to emit yet. StRun: rows 2 and up.
  typedef enum logic [0:0] {StFill, StRun} state_e;

  logic [DATA_WIDTH-1:0] r_lb1 [IMAGE_WIDTH];  // row r-1
  logic [DATA_WIDTH-1:0] r_lb2 [IMAGE_WIDTH];  // row r-2
  logic [DATA_WIDTH-1:0] r_win [9];            // index 3*row + col, 0 = oldest

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  state_e           r_state;
  logic             r_out_valid;

  logic w_xfer;
  logic w_col_last;
  logic w_row_last;
  logic w_emit;

  // A held window is the only stall; pixels seen during reset are dropped.
  assign in_ready   = rst | out_ready | ~r_out_valid;
  assign w_xfer     = in_valid & in_ready & ~rst;
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);
  assign w_emit     = w_xfer & (r_state == StRun) & (r_col >= COL_TWO);
  assign out_valid  = r_out_valid;

  // Counters, FSM and output-valid flag; everything freezes while a window is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_state     <= StFill;
      r_out_valid <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= w_emit;
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
      unique case (r_state)
        StFill: if (w_col_last && (r_row == ROW_ONE)) r_state <= StRun;
        StRun:  if (w_col_last && w_row_last) r_state <= StFill;
        default: r_state <= StFill;
      endcase
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Window shifts left one column per accepted pixel; new column enters on the right.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) r_win[k] <= '0;
    end else if (w_xfer) begin
      for (int i = 0; i < 3; i++) begin
        r_win[3*i]   <= r_win[3*i+1];
        r_win[3*i+1] <= r_win[3*i+2];
      end
      r_win[2] <= r_lb2[r_col];
      r_win[5] <= r_lb1[r_col];
      r_win[8] <= data_in;
    end
  end

  // Line buffers age the current column by one row; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_lb2[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= data_in;
    end
  end

  // Pack the window registers onto the kernel bus.
  always_comb begin
    kernel = '0;
    for (int k = 0; k < 9; k++) kernel[k*DATA_WIDTH +: DATA_WIDTH] = r_win[k];
  end

endmodule

// File: tb/tb_sliding_window_3x3.sv
// Bench for sliding_window_3x3: a 5x4 instance checked every cycle against a
// frame-level model, and a 3x3 instance checked with literal expectations.
module tb_sliding_window_3x3;

  localparam int AW = 5;
  localparam int AH = 4;
  localparam logic [71:0] FIRST_WIN = 72'h22_21_20_12_11_10_02_01_00;
  localparam logic [71:0] LAST_WIN  = 72'h34_33_32_24_23_22_14_13_12;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0]  a_data;
  logic [71:0] a_kernel;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_data;
  logic [71:0] b_kernel;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sliding_window_3x3 #(.DATA_WIDTH(8), .IMAGE_WIDTH(AW), .IMAGE_HEIGHT(AH)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .data_in   (a_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .kernel    (a_kernel)
  );

  sliding_window_3x3 #(.DATA_WIDTH(8), .IMAGE_WIDTH(3), .IMAGE_HEIGHT(3)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .data_in   (b_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .kernel    (b_kernel)
  );

  function automatic void chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endfunction

  // ---------------- frame-level model for instance A ----------------
  logic [7:0]  img [AW*AH];      // pixels of the current frame by raster index
  logic [71:0] exp_q[$];         // windows owed to the DUT, oldest first
  logic [71:0] got_q[$];         // windows the DUT handed over
  logic        m_ov = 1'b0;
  int          m_n  = 0;

  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*8 +: 8] = img[(r-2+i)*AW + (c-2+j)];
    return w;
  endfunction

  always @(negedge clk) begin
    logic exp_ir;
    logic nxt;
    exp_ir = rst ? 1'b1 : (a_out_ready | ~m_ov);
    chk("a_in_ready", {71'd0, a_in_ready}, {71'd0, exp_ir});
    chk("a_out_valid", {71'd0, a_out_valid}, {71'd0, m_ov});
    if (m_ov) begin
      if (exp_q.size() > 0) chk("a_kernel", a_kernel, exp_q[0]);
      else chk("a_kernel_unexpected", a_kernel, 72'hx);
    end
    if (rst) begin
      m_ov = 1'b0;
      m_n  = 0;
      exp_q.delete();
    end else begin
      nxt = m_ov & ~a_out_ready;
      if (m_ov && a_out_ready) begin
        got_q.push_back(a_kernel);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (a_in_valid && exp_ir) begin
        img[m_n] = a_data;
        if ((m_n / AW) >= 2 && (m_n % AW) >= 2) begin
          exp_q.push_back(exp_win(m_n / AW, m_n % AW));
          nxt = 1'b1;
        end
        m_n = (m_n + 1) % (AW * AH);
      end
      m_ov = nxt;
    end
  end

  // ---------------- window monitor for instance B ----------------
  int          b_cnt = 0;
  logic [71:0] b_last = '0;
  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      b_cnt++;
      b_last = b_kernel;
    end
  end

  // ---------------- drivers ----------------
  task automatic push_a(input logic [7:0] px, input int gap);
    bit acc;
    bit ok;
    ok = 1'b0;
    a_in_valid = 1'b1;
    a_data     = px;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      acc = a_in_ready;
      @(posedge clk);
      #1;
      if (acc) ok = 1'b1;
    end
    if (!ok) chk("a_push_timeout", 72'd0, 72'd1);
    a_in_valid = 1'b0;
    a_data     = 8'hff;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_b(input logic [7:0] px);
    bit acc;
    bit ok;
    ok = 1'b0;
    b_in_valid = 1'b1;
    b_data     = px;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      acc = b_in_ready;
      @(posedge clk);
      #1;
      if (acc) ok = 1'b1;
    end
    if (!ok) chk("b_push_timeout", 72'd0, 72'd1);
    b_in_valid = 1'b0;
    b_data     = 8'hee;
  endtask

  task automatic frame_a(input int gap);
    for (int r = 0; r < AH; r++)
      for (int c = 0; c < AW; c++)
        push_a(8'(r * 16 + c), gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_frame(input string tag, input int n_exp);
    chk({tag, "_count"}, 72'(got_q.size()), 72'(n_exp));
    if (got_q.size() == n_exp) begin
      chk({tag, "_first"}, got_q[0], FIRST_WIN);
      chk({tag, "_last"}, got_q[n_exp-1], LAST_WIN);
      chk({tag, "_k4"}, {64'd0, got_q[0][4*8 +: 8]}, 72'h11);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b1;
    a_in_valid  = 1'b1;  // presented during reset, must be dropped
    a_data      = 8'h55;
    a_out_ready = 1'b1;
    b_in_valid  = 1'b0;
    b_data      = 8'h00;
    b_out_ready = 1'b1;
    idle(2);
    rst        = 1'b0;
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {71'd0, a_out_valid}, 72'd0);
    chk("rst_kernel", a_kernel, 72'd0);
    chk("rst_in_ready", {71'd0, a_in_ready}, 72'd1);
    @(posedge clk);
    #1;

    // 3x3 image: one window equal to the whole image in raster order
    for (int i = 0; i < 9; i++) push_b(8'(i * 7 + 3));
    idle(4);
    chk("b_count", 72'(b_cnt), 72'd1);
    for (int i = 0; i < 9; i++) chk("b_elem", {64'd0, b_last[i*8 +: 8]}, 72'(i * 7 + 3));

    // continuous stream
    got_q.delete();
    frame_a(0);
    idle(4);
    check_frame("cont", 6);

    // first window stalled for 4 cycles
    got_q.delete();
    a_out_ready = 1'b0;
    fork
      frame_a(0);
      begin
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
          @(negedge clk);
          seen = a_out_valid;
        end
        if (!seen) chk("stall_wait_timeout", 72'd0, 72'd1);
        chk("stall_in_ready", {71'd0, a_in_ready}, 72'd0);
        chk("stall_kernel", a_kernel, FIRST_WIN);
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", {71'd0, a_in_ready}, 72'd0);
          chk("stall_kernel", a_kernel, FIRST_WIN);
        end
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
      end
    join
    idle(4);
    check_frame("stall", 6);

    // gaps on in_valid: 1,0,0,1,...
    got_q.delete();
    frame_a(2);
    idle(4);
    check_frame("gap", 6);

    // two frames back to back
    got_q.delete();
    frame_a(0);
    frame_a(0);
    idle(4);
    chk("b2b_count", 72'(got_q.size()), 72'd12);
    if (got_q.size() == 12) begin
      chk("b2b_w7", got_q[6], FIRST_WIN);
      chk("b2b_w12", got_q[11], LAST_WIN);
    end

    // reset mid-frame after pixel 0x13, then a fresh frame
    for (int i = 0; i < AW + 4; i++) push_a(8'((i / AW) * 16 + (i % AW)), 0);
    a_in_valid = 1'b1;
    a_data     = 8'h77;
    rst        = 1'b1;
    idle(1);
    rst        = 1'b0;
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {71'd0, a_out_valid}, 72'd0);
    @(posedge clk);
    #1;
    got_q.delete();
    frame_a(0);
    idle(4);
    check_frame("midrst", 6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
